// File: rtl/pokey_bus_pkg.sv
// Shared types for the POKEY bus master: access FSM states, register map and queued request layout.
package pokey_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GAP     = 3'd4
    } pokey_state_e;

    // Write-side register map
    localparam logic [3:0] ADDR_AUDF1  = 4'h0;
    localparam logic [3:0] ADDR_AUDC1  = 4'h1;
    localparam logic [3:0] ADDR_AUDF2  = 4'h2;
    localparam logic [3:0] ADDR_AUDC2  = 4'h3;
    localparam logic [3:0] ADDR_AUDF3  = 4'h4;
    localparam logic [3:0] ADDR_AUDC3  = 4'h5;
    localparam logic [3:0] ADDR_AUDF4  = 4'h6;
    localparam logic [3:0] ADDR_AUDC4  = 4'h7;
    localparam logic [3:0] ADDR_AUDCTL = 4'h8;
    localparam logic [3:0] ADDR_SKCTL  = 4'hF;

    // Read-side register map (POT0..POT7 share 0x0-0x7)
    localparam logic [3:0] ADDR_POT0   = 4'h0;
    localparam logic [3:0] ADDR_POT7   = 4'h7;
    localparam logic [3:0] ADDR_ALLPOT = 4'h8;

    typedef struct packed {
        logic       rd;
        logic [3:0] addr;
        logic [7:0] data;
    } pokey_req_t;

    localparam int REQ_W = $bits(pokey_req_t);

endpackage

// File: rtl/pokey_req_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit so full/empty come from the MSB compare.
module pokey_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_push_ok = i_push && !w_full;
    assign w_pop_ok  = i_pop && !w_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    // Ready depends only on registered pointers: a pop frees the slot one cycle later.
    assign o_ready = !w_full;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = w_empty;

endmodule

// File: rtl/pokey_bus_master.sv
// Queued CPU-side initiator for the POKEY register bus (SETUP/STROBE/RELEASE/GAP timing).
// Define POKEY_BUS_MASTER_SHADOW_EN to add a readable 16x8 shadow of the last value written per address.
module pokey_bus_master
    import pokey_bus_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic       phi2,
    input  logic       reset_n,
    // Request handshake: a request transfers on any rising edge where req_valid and req_ready are both high.
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rd,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       r_w_n,
    output logic       cs0_n,
    output logic       cs1_n,
    output logic [3:0] a,
    output logic [7:0] d_out,
    input  logic [7:0] d_in,
    output logic [2:0] o_dbg_state
`ifdef POKEY_BUS_MASTER_SHADOW_EN
    ,
    input  logic [3:0] shadow_addr,
    output logic [7:0] shadow_data
`endif
);

    localparam int CNT_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    pokey_state_e     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rwn;
    logic             r_cs_n;
    logic [3:0]       r_a;
    logic [7:0]       r_dout;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_data;
    pokey_req_t       w_head;
    logic             w_empty;
    logic             w_ready;
    logic             w_pop;

    pokey_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .i_clk   (phi2),
        .i_rst_n (reset_n),
        .i_push  (req_valid),
        .i_data  ({req_rd, req_addr, req_data}),
        .o_ready (w_ready),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty)
    );

    assign w_pop = (r_state == ST_IDLE) && !w_empty;

    always_ff @(posedge phi2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rwn       <= 1'b1;
            r_cs_n      <= 1'b1;
            r_a         <= '0;
            r_dout      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_a   <= w_head.addr;
                        r_rwn <= w_head.rd;
                        if (!w_head.rd) r_dout <= w_head.data;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_cs_n  <= 1'b0;
                    r_cnt   <= CNT_W'(STROBE_CYCLES - 1);
                    r_state <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (r_cnt == '0) begin
                        r_cs_n  <= 1'b1;
                        r_state <= ST_RELEASE;
                        // r_rwn still holds the direction of the access in flight
                        if (r_rwn) begin
                            r_rsp_data  <= d_in;
                            r_rsp_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_rwn <= 1'b1;
                    if (GAP_CYCLES == 0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= CNT_W'(GAP_CYCLES - 1);
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) r_state <= ST_IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef POKEY_BUS_MASTER_SHADOW_EN
    logic [7:0] r_shadow [16];

    // POKEY write registers cannot be read back, so keep our own copy at STROBE->RELEASE.
    always_ff @(posedge phi2 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) r_shadow[i] <= '0;
        end else if (r_state == ST_STROBE && r_cnt == '0 && !r_rwn) begin
            r_shadow[r_a] <= r_dout;
        end
    end

    assign shadow_data = r_shadow[shadow_addr];
`endif

    assign req_ready   = w_ready;
    assign busy        = !w_empty || (r_state != ST_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign r_w_n       = r_rwn;
    assign cs0_n       = r_cs_n;
    assign cs1_n       = r_cs_n;
    assign a           = r_a;
    assign d_out       = r_dout;
    assign o_dbg_state = r_state;

endmodule
